multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences a multi-cycle MIPS-subset datapath (PC, IR, Registers, ALU, ALU_Control, shared memory).

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Purpose : request/acknowledge link between the multi-cycle controller and
//           the unified instruction/data memory.
// Signals :
//   mem_req_o  controller -> memory  memory request, held until mem_ack_i
//   mem_we_o   controller -> memory  1 = write, 0 = read
//   iord_o     controller -> memory  address select: 0 = PC, 1 = ALUOut
//   mem_ack_i  memory -> controller  read data valid / write accepted
// Modports:
//   master  controller side
//   slave   memory side
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic mem_req_o;
  logic mem_we_o;
  logic iord_o;
  logic mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output iord_o,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  iord_o,
    output mem_ack_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Purpose : Moore FSM sequencing a multi-cycle MIPS-subset datapath. One
//           instruction spans 3-5 states (plus memory wait cycles). Every
//           datapath select and write strobe is decoded from the current
//           state, gated only by mem_ack_i (FETCH) and zero_i (BRANCH).
// Configuration macro:
//   ILLEGAL_TRAP_EN  defined   : illegal opcode parks the FSM in TRAP with
//                                trap_o = 1 until reset; not counted.
//                    undefined : illegal opcode is a NOP back to FETCH,
//                                counted as retired; trap_o tied 0.
// Parameters:
//   CNT_W         width of the retired-instruction counter
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   start_i       leave IDLE and begin fetching (ignored elsewhere)
//   op_i          IR[31:26] opcode, valid from DECODE onward
//   zero_i        ALU Zero flag
//   mem           memory handshake (req / we / iord / ack), master side
//   ir_write_o    load IR
//   pc_write_o    load PC
//   pc_src_o      00 = ALU, 01 = ALUOut, 10 = jump target
//   alu_src_a_o   0 = PC, 1 = RS
//   alu_src_b_o   00 = RT, 01 = 4, 10 = imm, 11 = imm << 2
//   alu_op_o      00 = add, 01 = sub, 10 = funct
//   reg_dst_o     0 = rt, 1 = rd
//   mem_to_reg_o  0 = ALUOut, 1 = MDR
//   reg_write_o   register-file write
//   state_o       current state encoding
//   retired_o     instructions completed (wraps)
//   trap_o        illegal-opcode trap
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [5:0]          op_i,
  input  logic                zero_i,
  multicycle_ctrl_if.master   mem,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          alu_op_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic [3:0]          state_o,
  output logic [CNT_W-1:0]    retired_o,
  output logic                trap_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEM_RD = 4'd4,
    S_WB_MEM = 4'd5,
    S_MEM_WR = 4'd6,
    S_EXEC_R = 4'd7,
    S_WB_R   = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_retired;
  logic               w_retire;

  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_iord;
  logic               w_ir_write;
  logic               w_pc_write;
  logic [1:0]         w_pc_src;
  logic               w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [1:0]         w_alu_op;
  logic               w_reg_dst;
  logic               w_mem_to_reg;
  logic               w_reg_write;
  logic               w_trap;

  // Opcode dispatch out of DECODE. Illegal opcodes either trap or fall back
  // to FETCH as a NOP depending on the build.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE: nxt = S_EXEC_R;
      OP_ADDI:  nxt = S_EXEC_I;
      OP_LW:    nxt = S_MEMADR;
      OP_SW:    nxt = S_MEMADR;
      OP_BEQ:   nxt = S_BRANCH;
      OP_J:     nxt = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
      default:  nxt = S_TRAP;
`else
      default:  nxt = S_FETCH;
`endif
    endcase
    return nxt;
  endfunction

  // State register; reset drops the FSM to IDLE immediately, aborting any
  // instruction in flight (outputs follow the state, so strobes drop too).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Memory states hold until acknowledged; ack seen in any
  // other state has no effect because it is only consulted here.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem.mem_ack_i) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: w_next = decode_next(op_i);
      S_MEMADR: begin
        if (op_i == OP_LW) begin
          w_next = S_MEM_RD;
        end else begin
          w_next = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem.mem_ack_i) begin
          w_next = S_WB_MEM;
        end else begin
          w_next = S_MEM_RD;
        end
      end
      S_WB_MEM: w_next = S_FETCH;
      S_MEM_WR: begin
        if (mem.mem_ack_i) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_MEM_WR;
        end
      end
      S_EXEC_R: w_next = S_WB_R;
      S_WB_R:   w_next = S_FETCH;
      S_EXEC_I: w_next = S_WB_I;
      S_WB_I:   w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      // Unused encodings (and TRAP when trapping is disabled) recover to IDLE.
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore output decode; everything defaults to 0 so each state lists only
  // what it asserts.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC + 4 computed every cycle; PC/IR load only with the data.
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem.mem_ack_i;
        w_pc_write  = mem.mem_ack_i;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        w_alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_iord    = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_WB_I: begin
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_pc_write  = zero_i;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      default: begin
        w_trap = 1'b0;
      end
    endcase
  end

  // An instruction retires when control returns to FETCH from a non-IDLE
  // state; FETCH waiting on itself is not a completion.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_IDLE) &&
                    (r_state != S_FETCH);

  // Retired-instruction counter, wraps naturally; cleared by reset so an
  // aborted instruction is never counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end else begin
      r_retired <= r_retired;
    end
  end

  assign mem.mem_req_o = w_mem_req;
  assign mem.mem_we_o  = w_mem_we;
  assign mem.iord_o    = w_iord;
  assign ir_write_o    = w_ir_write;
  assign pc_write_o    = w_pc_write;
  assign pc_src_o      = w_pc_src;
  assign alu_src_a_o   = w_alu_src_a;
  assign alu_src_b_o   = w_alu_src_b;
  assign alu_op_o      = w_alu_op;
  assign reg_dst_o     = w_reg_dst;
  assign mem_to_reg_o  = w_mem_to_reg;
  assign reg_write_o   = w_reg_write;
  assign state_o       = r_state;
  assign retired_o     = r_retired;
`ifdef ILLEGAL_TRAP_EN
  assign trap_o        = w_trap;
`else
  assign trap_o        = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Drives instruction traces from a vector table through the controller,
// acting as a memory that acknowledges on the last cycle of each request run.
// Expected control words are pushed to a scoreboard queue as stimulus is
// planned, then popped and compared one cycle at a time.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [5:0]        op_i;
  logic              zero_i;
  logic              ir_write_o;
  logic              pc_write_o;
  logic [1:0]        pc_src_o;
  logic              alu_src_a_o;
  logic [1:0]        alu_src_b_o;
  logic [1:0]        alu_op_o;
  logic              reg_dst_o;
  logic              mem_to_reg_o;
  logic              reg_write_o;
  logic [3:0]        state_o;
  logic [CNT_W-1:0]  retired_o;
  logic              trap_o;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .op_i         (op_i),
    .zero_i       (zero_i),
    .mem          (mif),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .state_o      (state_o),
    .retired_o    (retired_o),
    .trap_o       (trap_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic       trap;
  } ctrl_t;

  typedef struct {
    logic             start;
    logic [5:0]       op;
    logic             ack;
    logic             zero;
    ctrl_t            exp;
    logic [CNT_W-1:0] ret;
    int               tag;
  } sb_item_t;

  // One table row = one instruction: inputs plus the expected state path
  // (memory waits included) and the expected retired-count increment.
  typedef struct {
    logic [5:0]       op;
    logic             zero;
    logic             noise;
    int               len;
    logic [0:11][3:0] path;
    int               inc;
  } vec_t;

  sb_item_t          sb[$];
  vec_t              vecs[9];
  int                n_checks = 0;
  int                n_errors = 0;
  logic [CNT_W-1:0]  exp_ret;

  function automatic vec_t mk(logic [5:0] op, logic zero, logic noise, int len,
                              logic [0:11][3:0] path, int inc);
    vec_t v;
    v.op = op; v.zero = zero; v.noise = noise; v.len = len; v.path = path; v.inc = inc;
    return v;
  endfunction

  // Expected control word for a state, straight from the state/output table.
  function automatic ctrl_t ctrl_of(logic [3:0] st, logic ack, logic zero);
    ctrl_t c;
    c = '0;
    c.st = st;
    case (st)
      4'd1:  begin c.req = 1'b1; c.srcb = 2'b01; c.irw = ack; c.pcw = ack; end
      4'd2:  begin c.srcb = 2'b11; end
      4'd3:  begin c.srca = 1'b1; c.srcb = 2'b10; end
      4'd4:  begin c.req = 1'b1; c.iord = 1'b1; end
      4'd5:  begin c.regw = 1'b1; c.m2r = 1'b1; end
      4'd6:  begin c.req = 1'b1; c.we = 1'b1; c.iord = 1'b1; end
      4'd7:  begin c.srca = 1'b1; c.aluop = 2'b10; end
      4'd8:  begin c.regw = 1'b1; c.regdst = 1'b1; end
      4'd9:  begin c.srca = 1'b1; c.srcb = 2'b10; end
      4'd10: begin c.regw = 1'b1; end
      4'd11: begin c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcw = zero; end
      4'd12: begin c.pcsrc = 2'b10; c.pcw = 1'b1; end
      4'd13: begin c.trap = 1'b1; end
      default: c = c;
    endcase
    return c;
  endfunction

  function automatic logic is_req(logic [3:0] st);
    return (st == 4'd1) || (st == 4'd4) || (st == 4'd6);
  endfunction

  function automatic ctrl_t actual();
    ctrl_t a;
    a.st = state_o; a.req = mif.mem_req_o; a.we = mif.mem_we_o; a.iord = mif.iord_o;
    a.irw = ir_write_o; a.pcw = pc_write_o; a.pcsrc = pc_src_o; a.srca = alu_src_a_o;
    a.srcb = alu_src_b_o; a.aluop = alu_op_o; a.regdst = reg_dst_o;
    a.m2r = mem_to_reg_o; a.regw = reg_write_o; a.trap = trap_o;
    return a;
  endfunction

  task automatic chk(input string name, input int tag, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s tag=%0d actual=%0h required=%0h", name, tag, act, req);
    end
  endtask

  task automatic push(input logic start, input logic [5:0] op, input logic ack,
                      input logic zero, input logic [3:0] st, input int tag);
    sb_item_t it;
    it.start = start; it.op = op; it.ack = ack; it.zero = zero;
    it.exp = ctrl_of(st, ack, zero); it.ret = exp_ret; it.tag = tag;
    sb.push_back(it);
  endtask

  // Apply each queued cycle at the falling edge and compare shortly after.
  task automatic run_queue();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk_i);
      start_i = it.start; op_i = it.op; zero_i = it.zero; mif.mem_ack_i = it.ack;
      #1;
      chk("ctrl", it.tag, 64'(actual()), 64'(it.exp));
      chk("retired", it.tag, 64'(retired_o), 64'(it.ret));
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; op_i = 6'd0; zero_i = 1'b0; mif.mem_ack_i = 1'b0;
    exp_ret = '0;

    vecs[0] = mk(6'b000000, 1'b0, 1'b0, 4,  {4'd1, 4'd2, 4'd7, 4'd8, 32'd0}, 1);
    vecs[1] = mk(6'b100011, 1'b0, 1'b0, 11, {4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3,
                                             4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0}, 1);
    vecs[2] = mk(6'b101011, 1'b0, 1'b0, 6,  {4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 24'd0}, 1);
    vecs[3] = mk(6'b001000, 1'b0, 1'b1, 4,  {4'd1, 4'd2, 4'd9, 4'd10, 32'd0}, 1);
    vecs[4] = mk(6'b000100, 1'b0, 1'b0, 3,  {4'd1, 4'd2, 4'd11, 36'd0}, 1);
    vecs[5] = mk(6'b000100, 1'b1, 1'b0, 3,  {4'd1, 4'd2, 4'd11, 36'd0}, 1);
    vecs[6] = mk(6'b000010, 1'b0, 1'b1, 3,  {4'd1, 4'd2, 4'd12, 36'd0}, 1);
    vecs[7] = mk(6'b100011, 1'b1, 1'b0, 5,  {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 28'd0}, 1);
`ifdef ILLEGAL_TRAP_EN
    vecs[8] = mk(6'b111111, 1'b0, 1'b1, 5,  {4'd1, 4'd2, 4'd13, 4'd13, 4'd13, 28'd0}, 0);
`else
    vecs[8] = mk(6'b111111, 1'b0, 1'b0, 2,  {4'd1, 4'd2, 40'd0}, 1);
`endif

    // Reset held: everything at zero.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ctrl", 0, 64'(actual()), 64'(ctrl_of(4'd0, 1'b0, 1'b0)));
    chk("rst_ret", 0, 64'(retired_o), 64'd0);
    rst_i = 1'b1;

    // Idle with start low for 5 cycles (stray acks ignored), then start.
    for (int k = 0; k < 5; k++) push(1'b0, 6'd0, k[0], 1'b0, 4'd0, 100 + k);
    push(1'b1, 6'd0, 1'b0, 1'b0, 4'd0, 105);
    run_queue();

    // Table-driven instruction traces.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < vecs[v].len; k++) begin
        logic [3:0] st;
        logic       ack;
        st = vecs[v].path[k];
        if (is_req(st)) begin
          ack = (k == vecs[v].len - 1) || (vecs[v].path[k + 1] != st);
        end else begin
          ack = vecs[v].noise;
        end
        push(vecs[v].noise, vecs[v].op, ack, vecs[v].zero, st, 1000 * (v + 1) + k);
      end
      run_queue();
      exp_ret = exp_ret + CNT_W'(vecs[v].inc);
    end

    // Reset clears the count (and leaves TRAP when trapping is built in).
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0; mif.mem_ack_i = 1'b0;
    #1;
    chk("rst2_state", 1, 64'(state_o), 64'd0);
    chk("rst2_ret", 1, 64'(retired_o), 64'd0);
    chk("rst2_trap", 1, 64'(trap_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_ret = '0;

    // add, then sw stuck waiting in MEM_WR.
    push(1'b1, 6'b000000, 1'b0, 1'b0, 4'd0, 600);
    push(1'b0, 6'b000000, 1'b1, 1'b0, 4'd1, 601);
    push(1'b0, 6'b000000, 1'b0, 1'b0, 4'd2, 602);
    push(1'b0, 6'b000000, 1'b0, 1'b0, 4'd7, 603);
    push(1'b0, 6'b000000, 1'b0, 1'b0, 4'd8, 604);
    run_queue();
    exp_ret = exp_ret + CNT_W'(1);
    push(1'b0, 6'b101011, 1'b1, 1'b0, 4'd1, 610);
    push(1'b0, 6'b101011, 1'b0, 1'b0, 4'd2, 611);
    push(1'b0, 6'b101011, 1'b0, 1'b0, 4'd3, 612);
    for (int k = 0; k < 3; k++) push(1'b0, 6'b101011, 1'b0, 1'b0, 4'd6, 613 + k);
    run_queue();

    // Abort mid-wait: request and write drop at once, count cleared.
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("abort_req", 2, 64'(mif.mem_req_o), 64'd0);
    chk("abort_we", 2, 64'(mif.mem_we_o), 64'd0);
    chk("abort_state", 2, 64'(state_o), 64'd0);
    chk("abort_ret", 2, 64'(retired_o), 64'd0);
    @(negedge clk_i);
    mif.mem_ack_i = 1'b1; start_i = 1'b1;
    #1;
    chk("abort_hold", 3, 64'(actual()), 64'(ctrl_of(4'd0, 1'b0, 1'b0)));
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b0; mif.mem_ack_i = 1'b0;
    exp_ret = '0;
    push(1'b0, 6'b101011, 1'b1, 1'b0, 4'd0, 700);
    push(1'b0, 6'b101011, 1'b1, 1'b0, 4'd0, 701);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
